// File: rtl/scan_pkg.sv
// Shared definitions for the scanner transfer controller: controller states,
// frame geometry and the round-robin pick between the two scanners.
package scan_pkg;

   localparam int SCAN_DEPTH_C = 10;
   localparam int BYTE_W       = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_SAMPLE,
      ST_PUSH,
      ST_STEP,
      ST_WAIT,
      ST_CKSUM,
      ST_DONE
   } state_t;

   // Both ready: serve the one not served last. Otherwise serve whichever is ready.
   function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
      return (r0 && r1) ? ~last : r1;
   endfunction

endpackage

// File: rtl/scan_xfer_ctrl_if.sv
// Host-side byte stream of the scanner transfer controller (valid/ready,
// with a last-byte marker). The controller is the master.
interface scan_xfer_ctrl_if;
   import scan_pkg::*;

   logic [BYTE_W-1:0] out_data;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_last, output out_valid, input out_ready);
   modport slave  (input out_data, input out_last, input out_valid, output out_ready);

endinterface

// File: rtl/xfer_fifo.sv
// Output FIFO: data + last flag, DEPTH entries (power of two).
// A push is refused while full even if a pop happens in the same cycle;
// a pop while empty is ignored. The head reads as zero while empty.
module xfer_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_rdata = o_empty ? '0 : r_mem[r_rd];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_wdata;
   end

endmodule

// File: rtl/scan_xfer_ctrl.sv
// Round-robin consumer for two scanners. Grants one scanner, steps its read
// address one byte at a time (waiting READ_LAT cycles per byte), and packs
// the frame into the output FIFO with the last byte of the frame marked.
// Optional feature macro: SCAN_XFER_CKSUM_EN appends a mod-256 sum byte to
// each frame; that byte then carries the last marker.
module scan_xfer_ctrl import scan_pkg::*; #(
   parameter int SCAN_DEPTH = SCAN_DEPTH_C,
   parameter int READ_LAT   = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_ready_to_transfer_0,
   input  logic              i_ready_to_transfer_1,
   input  logic [BYTE_W-1:0] i_data_in_0,
   input  logic [BYTE_W-1:0] i_data_in_1,
   output logic              o_transfer_0,
   output logic              o_transfer_1,
   output logic              o_read_inc_0,
   output logic              o_read_inc_1,
   scan_xfer_ctrl_if.master  host,
   output logic              o_busy,
   output logic              o_sel,
   output logic [7:0]        o_frame_count
);

   localparam int WAIT_W = $clog2(READ_LAT + 1);

   state_t            r_state;
   logic              r_sel;
   logic              r_last;
   logic [WAIT_W-1:0] r_wait;
   logic [3:0]        r_idx;
   logic [BYTE_W-1:0] r_hold;
   logic              r_transfer_0;
   logic              r_transfer_1;
   logic              r_read_inc_0;
   logic              r_read_inc_1;
   logic              r_busy;
   logic [7:0]        r_frame_count;
`ifdef SCAN_XFER_CKSUM_EN
   logic [BYTE_W-1:0] r_sum;
`endif

   logic              w_pick;
   logic              w_sel_ready;
   logic [BYTE_W-1:0] w_sel_data;
   logic              w_idx_last;
   logic              w_fifo_push;
   logic [BYTE_W:0]   w_fifo_wdata;
   logic [BYTE_W:0]   w_fifo_rdata;
   logic              w_full;
   logic              w_empty;

   assign w_pick      = rr_pick(i_ready_to_transfer_0, i_ready_to_transfer_1, r_last);
   assign w_sel_ready = r_sel ? i_ready_to_transfer_1 : i_ready_to_transfer_0;
   assign w_sel_data  = r_sel ? i_data_in_1 : i_data_in_0;
   assign w_idx_last  = (r_idx == 4'(SCAN_DEPTH - 1));

   // FIFO write request and payload for the byte or sum being emitted.
   always_comb begin
      w_fifo_push  = 1'b0;
      w_fifo_wdata = {w_idx_last, r_hold};
`ifdef SCAN_XFER_CKSUM_EN
      w_fifo_wdata = {1'b0, r_hold};
      if (r_state == ST_CKSUM) w_fifo_wdata = {1'b1, r_sum};
      w_fifo_push = ((r_state == ST_PUSH) || (r_state == ST_CKSUM)) && !w_full;
`else
      w_fifo_push = (r_state == ST_PUSH) && !w_full;
`endif
   end

   // Transfer sequencer: arbitration, per-byte read pacing and frame close-out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_sel         <= 1'b0;
         r_last        <= 1'b1;
         r_wait        <= '0;
         r_idx         <= '0;
         r_transfer_0  <= 1'b0;
         r_transfer_1  <= 1'b0;
         r_read_inc_0  <= 1'b0;
         r_read_inc_1  <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_read_inc_0 <= 1'b0;
         r_read_inc_1 <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_ready_to_transfer_0 || i_ready_to_transfer_1) begin
                  r_sel        <= w_pick;
                  r_transfer_0 <= ~w_pick;
                  r_transfer_1 <= w_pick;
                  r_busy       <= 1'b1;
                  r_state      <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               r_wait  <= WAIT_W'(READ_LAT);
               r_idx   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_wait == WAIT_W'(1)) r_state <= ST_SAMPLE;
               else                      r_wait  <= r_wait - 1'b1;
            end
            ST_SAMPLE: begin
               r_state <= ST_PUSH;
            end
            ST_PUSH: begin
               if (!w_full) begin
                  if (!w_idx_last) begin
                     r_read_inc_0 <= ~r_sel;
                     r_read_inc_1 <= r_sel;
                     r_state      <= ST_STEP;
                  end else begin
`ifdef SCAN_XFER_CKSUM_EN
                     r_state <= ST_CKSUM;
`else
                     r_transfer_0  <= 1'b0;
                     r_transfer_1  <= 1'b0;
                     r_frame_count <= r_frame_count + 8'd1;
                     r_last        <= r_sel;
                     r_state       <= ST_DONE;
`endif
                  end
               end
            end
            ST_STEP: begin
               r_idx   <= r_idx + 4'd1;
               r_wait  <= WAIT_W'(READ_LAT);
               r_state <= ST_WAIT;
            end
`ifdef SCAN_XFER_CKSUM_EN
            ST_CKSUM: begin
               if (!w_full) begin
                  r_transfer_0  <= 1'b0;
                  r_transfer_1  <= 1'b0;
                  r_frame_count <= r_frame_count + 8'd1;
                  r_last        <= r_sel;
                  r_state       <= ST_DONE;
               end
            end
`endif
            ST_DONE: begin
               // Hold here until the served scanner withdraws its frame.
               if (!w_sel_ready) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Byte holding register, loaded when the scanner output has settled.
   always_ff @(posedge clk) begin
      if (r_state == ST_SAMPLE) r_hold <= w_sel_data;
   end

`ifdef SCAN_XFER_CKSUM_EN
   // Running mod-256 frame sum, cleared at grant.
   always_ff @(posedge clk) begin
      if (r_state == ST_GRANT)       r_sum <= '0;
      else if (r_state == ST_SAMPLE) r_sum <= r_sum + w_sel_data;
   end
`endif

   xfer_fifo #(
      .WIDTH (BYTE_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_fifo_push),
      .i_wdata (w_fifo_wdata),
      .i_pop   (host.out_ready),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign host.out_valid = ~w_empty;
   assign host.out_data  = w_fifo_rdata[BYTE_W-1:0];
   assign host.out_last  = w_fifo_rdata[BYTE_W];

   assign o_transfer_0  = r_transfer_0;
   assign o_transfer_1  = r_transfer_1;
   assign o_read_inc_0  = r_read_inc_0;
   assign o_read_inc_1  = r_read_inc_1;
   assign o_busy        = r_busy;
   assign o_sel         = r_sel;
   assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_scan_xfer_ctrl.sv
// Directed bench for scan_xfer_ctrl: behavioural scanner pair, byte
// scoreboard on the host stream, and per-cycle grant exclusivity checks.
module tb_scan_xfer_ctrl;
   import scan_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rdy0 = 1'b0;
   logic       rdy1 = 1'b0;
   logic [7:0] din0;
   logic [7:0] din1;
   logic       xfer0, xfer1, rinc0, rinc1, busy, sel;
   logic [7:0] fc;

   logic [7:0] frame0 [16];
   logic [7:0] frame1 [16];
   logic [3:0] ptr0 = '0;
   logic [3:0] ptr1 = '0;
   logic [8:0] sb [$];
   logic [8:0] exp_b;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   scan_xfer_ctrl_if host_if ();

   scan_xfer_ctrl dut (
      .clk                   (clk),
      .rst                   (rst),
      .i_ready_to_transfer_0 (rdy0),
      .i_ready_to_transfer_1 (rdy1),
      .i_data_in_0           (din0),
      .i_data_in_1           (din1),
      .o_transfer_0          (xfer0),
      .o_transfer_1          (xfer1),
      .o_read_inc_0          (rinc0),
      .o_read_inc_1          (rinc1),
      .host                  (host_if),
      .o_busy                (busy),
      .o_sel                 (sel),
      .o_frame_count         (fc)
   );

   // Scanner models: read address restarts whenever transfer is low.
   always @(posedge clk) begin
      if (rst || !xfer0) ptr0 <= '0;
      else if (rinc0)    ptr0 <= ptr0 + 4'd1;
      if (rst || !xfer1) ptr1 <= '0;
      else if (rinc1)    ptr1 <= ptr1 + 4'd1;
   end
   assign din0 = frame0[ptr0];
   assign din1 = frame1[ptr1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Host-side monitor and grant exclusivity.
   always @(negedge clk) begin
      if (!rst) begin
         chk("grant_excl", {31'b0, (xfer0 && xfer1) || (rinc0 && !xfer0) || (rinc1 && !xfer1)}, 32'd0);
         if (host_if.out_valid && host_if.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_byte_queue_size", 32'(sb.size()), 32'd1);
            end else begin
               exp_b = sb.pop_front();
               chk("out_byte", {23'b0, host_if.out_last, host_if.out_data}, {23'b0, exp_b});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic load(input int which, input logic [7:0] base, input bit incr);
      for (int i = 0; i < 16; i++) begin
         if (which == 0) frame0[i] = incr ? 8'(int'(base) + i) : base;
         else            frame1[i] = incr ? 8'(int'(base) + i) : base;
      end
   endtask

   task automatic expect_frame(input int which);
      logic [7:0] s;
      logic [7:0] b;
      s = 8'd0;
      for (int i = 0; i < SCAN_DEPTH_C; i++) begin
         b = (which == 0) ? frame0[i] : frame1[i];
         s = s + b;
`ifdef SCAN_XFER_CKSUM_EN
         sb.push_back({1'b0, b});
`else
         sb.push_back({(i == SCAN_DEPTH_C - 1), b});
`endif
      end
`ifdef SCAN_XFER_CKSUM_EN
      sb.push_back({1'b1, s});
`endif
   endtask

   task automatic wait_fc(input logic [7:0] n, input string tag);
      int k;
      k = 0;
      while (fc !== n && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk(tag, {24'b0, fc}, {24'b0, n});
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while ((sb.size() != 0 || host_if.out_valid) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      int bad;
      int lastc;
      int r1;
      host_if.out_ready = 1'b0;
      load(0, 8'h10, 1'b1);
      load(1, 8'h80, 1'b1);

      // Reset values
      repeat (3) step();
      @(negedge clk);
      chk("rst_transfer_0", {31'b0, xfer0}, 32'd0);
      chk("rst_transfer_1", {31'b0, xfer1}, 32'd0);
      chk("rst_read_inc_0", {31'b0, rinc0}, 32'd0);
      chk("rst_read_inc_1", {31'b0, rinc1}, 32'd0);
      chk("rst_out_valid", {31'b0, host_if.out_valid}, 32'd0);
      chk("rst_out_data", {24'b0, host_if.out_data}, 32'd0);
      chk("rst_out_last", {31'b0, host_if.out_last}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_sel", {31'b0, sel}, 32'd0);
      chk("rst_frame_count", {24'b0, fc}, 32'd0);
      step();
      rst = 1'b0;

      // Single scanner 0 frame, bytes 0x10..0x19
      expect_frame(0);
      host_if.out_ready = 1'b1;
      rdy0 = 1'b1;
      @(negedge clk);
      chk("t1_transfer_pre", {31'b0, xfer0}, 32'd0);
      @(negedge clk);
      chk("t1_transfer_rise", {31'b0, xfer0}, 32'd1);
      chk("t1_busy", {31'b0, busy}, 32'd1);
      pulses = 0; bad = 0; lastc = 0; r1 = 0;
      for (int c = 0; c < 400 && fc !== 8'd1; c++) begin
         @(negedge clk);
         if (rinc0) begin
            if (pulses > 0 && (c - lastc) != 7) bad++;
            lastc = c;
            pulses++;
         end
         if (rinc1) r1++;
      end
      chk("t1_frame_count", {24'b0, fc}, 32'd1);
      chk("t1_read_inc_pulses", 32'(pulses), 32'd9);
      chk("t1_read_inc_bad_spacing", 32'(bad), 32'd0);
      chk("t1_read_inc_1_pulses", 32'(r1), 32'd0);
      chk("t1_done_transfer_low", {31'b0, xfer0}, 32'd0);
      chk("t1_done_busy", {31'b0, busy}, 32'd1);
      step();
      rdy0 = 1'b0;
      wait_drain("t1_drain");
      repeat (3) step();
      chk("t1_idle_busy", {31'b0, busy}, 32'd0);
      chk("t1_idle_sel", {31'b0, sel}, 32'd0);

      // Both ready from reset: scanner 0 then scanner 1
      do_reset();
      load(0, 8'h10, 1'b1);
      load(1, 8'h80, 1'b1);
      expect_frame(0);
      expect_frame(1);
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      wait_fc(8'd1, "t2_frame_count_1");
      chk("t2_sel_first", {31'b0, sel}, 32'd0);
      step();
      rdy0 = 1'b0;
      wait_fc(8'd2, "t2_frame_count_2");
      chk("t2_sel_second", {31'b0, sel}, 32'd1);
      step();
      rdy1 = 1'b0;
      wait_drain("t2_drain");

      // Back-pressure over two frames, then push/pop at full
      do_reset();
      load(0, 8'h20, 1'b1);
      load(1, 8'h40, 1'b1);
      expect_frame(0);
      expect_frame(1);
      host_if.out_ready = 1'b0;
      rdy0 = 1'b1;
      wait_fc(8'd1, "t3_frame_count_1");
      step();
      rdy0 = 1'b0;
      rdy1 = 1'b1;
      for (int c = 0; c < 400 && dut.u_fifo.r_count != 5'd16; c++) @(negedge clk);
      repeat (10) @(negedge clk);
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (rinc1) pulses++;
      end
      chk("t3_fifo_full_count", 32'(dut.u_fifo.r_count), 32'd16);
      chk("t3_stall_read_inc", 32'(pulses), 32'd0);
      chk("t3_stall_transfer_1", {31'b0, xfer1}, 32'd1);
      chk("t3_stall_busy", {31'b0, busy}, 32'd1);
      chk("t3_stall_frame_count", {24'b0, fc}, 32'd1);
      step();
      host_if.out_ready = 1'b1;
      @(negedge clk);
      chk("t3_pp_count_16", 32'(dut.u_fifo.r_count), 32'd16);
      step();
      host_if.out_ready = 1'b0;
      @(negedge clk);
      chk("t3_pp_count_15", 32'(dut.u_fifo.r_count), 32'd15);
      step();
      @(negedge clk);
      chk("t3_pp_count_16_again", 32'(dut.u_fifo.r_count), 32'd16);
      step();
      host_if.out_ready = 1'b1;
      wait_fc(8'd2, "t3_frame_count_2");
      step();
      rdy1 = 1'b0;
      wait_drain("t3_drain");

      // Reset during byte 5, then a fresh frame from byte 0
      do_reset();
      load(0, 8'h30, 1'b1);
      expect_frame(0);
      rdy0 = 1'b1;
      pulses = 0;
      for (int c = 0; c < 400 && pulses < 5; c++) begin
         @(negedge clk);
         if (rinc0) pulses++;
      end
      chk("t4_pulses_before_reset", 32'(pulses), 32'd5);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("t4_transfer_0", {31'b0, xfer0}, 32'd0);
      chk("t4_out_valid", {31'b0, host_if.out_valid}, 32'd0);
      chk("t4_busy", {31'b0, busy}, 32'd0);
      chk("t4_read_inc_0", {31'b0, rinc0}, 32'd0);
      chk("t4_frame_count", {24'b0, fc}, 32'd0);
      expect_frame(0);
      wait_fc(8'd1, "t4_restart_frame_count");
      step();
      rdy0 = 1'b0;
      wait_drain("t4_drain");

      // Constant 0xFF frame (sum byte 0xF6 when the checksum is built in)
      do_reset();
      load(0, 8'hFF, 1'b0);
      expect_frame(0);
      rdy0 = 1'b1;
      wait_fc(8'd1, "t5_frame_count");
      step();
      rdy0 = 1'b0;
      wait_drain("t5_drain");

      repeat (2) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
